// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - frame-based ON/OFF blink controller driven by vsync rising edges
module blink_sequencer #(
    parameter int ON_FRAMES    = 30,
    parameter int OFF_FRAMES   = 30,
    parameter int CNT_WIDTH    = 8,
    parameter int REPEAT_WIDTH = 4
) (
    input  logic                    i_pclk,
    input  logic                    i_rst,
    input  logic                    i_vsync,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [REPEAT_WIDTH-1:0] i_repeat,
    output logic                    o_blink,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [CNT_WIDTH-1:0]    ON_LAST  = CNT_WIDTH'(ON_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0]    OFF_LAST = CNT_WIDTH'(OFF_FRAMES - 1);
    localparam logic [REPEAT_WIDTH-1:0] REP_ONE  = REPEAT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_frame_cnt;
    logic [REPEAT_WIDTH-1:0] r_rep_left;
    logic                    r_vsync_q;
    logic                    w_frame_tick;

    // One tick per vsync rising edge, regardless of how long vsync stays high
    assign w_frame_tick = i_vsync & ~r_vsync_q;

    // Delay vsync by one cycle for edge detection
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= i_vsync;
        end
    end

    // Sequencer FSM; outputs are registered alongside the state they decode
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_rep_left  <= '0;
            o_blink     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start && !i_stop) begin
                        r_state     <= S_ON;
                        r_frame_cnt <= '0;
                        r_rep_left  <= i_repeat;
                        o_blink     <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                S_ON: begin
                    if (i_stop) begin
                        r_state     <= S_DONE;
                        r_frame_cnt <= '0;
                        o_blink     <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                    end else if (w_frame_tick) begin
                        if (r_frame_cnt == ON_LAST) begin
                            r_state     <= S_OFF;
                            r_frame_cnt <= '0;
                            o_blink     <= 1'b0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                S_OFF: begin
                    if (i_stop) begin
                        r_state     <= S_DONE;
                        r_frame_cnt <= '0;
                        o_blink     <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                    end else if (w_frame_tick) begin
                        if (r_frame_cnt == OFF_LAST) begin
                            r_frame_cnt <= '0;
                            if (r_rep_left == REP_ONE) begin
                                r_state <= S_DONE;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end else begin
                                // Zero means run forever, so it is never decremented
                                if (r_rep_left != '0) begin
                                    r_rep_left <= r_rep_left - REP_ONE;
                                end
                                r_state <= S_ON;
                                o_blink <= 1'b1;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_blink <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_blink <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - directed self-checking bench for blink_sequencer
module tb_blink_sequencer;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       start;
    logic       stop;
    logic [3:0] rep;

    logic a_blink, a_busy, a_done;
    logic b_blink, b_busy, b_done;
    logic c_blink, c_busy, c_done;

    int n_cmp;
    int n_err;
    int a_done_cnt;
    int b_done_cnt;
    int c_done_cnt;

    blink_sequencer #(.ON_FRAMES(2), .OFF_FRAMES(1), .CNT_WIDTH(8), .REPEAT_WIDTH(4)) u_a (
        .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_start(start), .i_stop(stop),
        .i_repeat(rep), .o_blink(a_blink), .o_busy(a_busy), .o_done(a_done)
    );

    blink_sequencer #(.ON_FRAMES(1), .OFF_FRAMES(1), .CNT_WIDTH(8), .REPEAT_WIDTH(4)) u_b (
        .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_start(start), .i_stop(stop),
        .i_repeat(rep), .o_blink(b_blink), .o_busy(b_busy), .o_done(b_done)
    );

    blink_sequencer #(.ON_FRAMES(3), .OFF_FRAMES(2), .CNT_WIDTH(8), .REPEAT_WIDTH(4)) u_c (
        .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_start(start), .i_stop(stop),
        .i_repeat(rep), .o_blink(c_blink), .o_busy(c_busy), .o_done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of o_done pulses per instance, sampled on the falling edge
    always @(negedge clk) begin
        if (a_done) a_done_cnt = a_done_cnt + 1;
        if (b_done) b_done_cnt = b_done_cnt + 1;
        if (c_done) c_done_cnt = c_done_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] r);
        start = 1'b1;
        rep   = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int base;
    logic [5:0] exp_t2;

    initial begin
        n_cmp = 0; n_err = 0;
        a_done_cnt = 0; b_done_cnt = 0; c_done_cnt = 0;
        vsync = 1'b0; start = 1'b0; stop = 1'b0; rep = 4'd0;

        // 1: asynchronous reset before any clock edge
        rst = 1'b1;
        #2;
        chk("rst_blink", int'(a_blink), 0);
        chk("rst_busy",  int'(a_busy),  0);
        chk("rst_done",  int'(a_done),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(a_busy), 0);
        chk("idle_blink", int'(a_blink), 0);

        // start together with stop is refused
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", int'(a_busy), 0);

        // 2: ON=2 OFF=1 repeat=2, six ticks
        base = a_done_cnt;
        do_start(4'd2);
        chk("t2_busy_lat1", int'(a_busy), 1);
        exp_t2 = 6'b011011;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_blink_f%0d", k), int'(a_blink), int'(exp_t2[k]));
            pulse_vsync();
        end
        @(negedge clk);
        chk("t2_done_once", a_done_cnt - base, 1);
        chk("t2_busy_end", int'(a_busy), 0);
        chk("t2_blink_end", int'(a_blink), 0);

        // 3: infinite run ON=OFF=1
        do_reset();
        base = b_done_cnt;
        do_start(4'd0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t3_blink_f%0d", k), int'(b_blink), (k % 2 == 0) ? 1 : 0);
            pulse_vsync();
        end
        chk("t3_no_done", b_done_cnt - base, 0);
        chk("t3_busy", int'(b_busy), 1);

        // 4: stop mid-ON, then a full restart
        do_reset();
        do_start(4'd1);
        pulse_vsync();
        chk("t4_on_after1", int'(a_blink), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_stop_blink", int'(a_blink), 0);
        chk("t4_stop_done", int'(a_done), 1);
        chk("t4_stop_busy", int'(a_busy), 0);
        @(negedge clk);
        chk("t4_done_1cyc", int'(a_done), 0);
        chk("t4_idle_busy", int'(a_busy), 0);
        base = a_done_cnt;
        // a tick coinciding with the start must not count
        start = 1'b1; rep = 4'd1; vsync = 1'b1;
        @(negedge clk);
        start = 1'b0; vsync = 1'b0;
        @(negedge clk);
        chk("t4r_blink_f0", int'(a_blink), 1);
        pulse_vsync();
        chk("t4r_blink_f1", int'(a_blink), 1);
        pulse_vsync();
        chk("t4r_blink_f2", int'(a_blink), 0);
        chk("t4r_busy_off", int'(a_busy), 1);
        pulse_vsync();
        @(negedge clk);
        chk("t4r_done", a_done_cnt - base, 1);
        chk("t4r_busy_end", int'(a_busy), 0);

        // 5: long vsync high counts once; start while busy ignored
        do_reset();
        base = c_done_cnt;
        do_start(4'd1);
        vsync = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b1; rep = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        chk("t5_still_on", int'(c_blink), 1);
        pulse_vsync();
        chk("t5_on_tick2", int'(c_blink), 1);
        pulse_vsync();
        chk("t5_off_tick3", int'(c_blink), 0);
        pulse_vsync();
        chk("t5_off_tick4", int'(c_busy), 1);
        pulse_vsync();
        @(negedge clk);
        chk("t5_done", c_done_cnt - base, 1);
        chk("t5_rep_kept", int'(c_busy), 0);

        // 6: async reset during OFF
        do_reset();
        do_start(4'd0);
        pulse_vsync();
        pulse_vsync();
        chk("t6_in_off_blink", int'(a_blink), 0);
        chk("t6_in_off_busy", int'(a_busy), 1);
        base = a_done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_busy", int'(a_busy), 0);
        chk("t6_async_blink", int'(a_blink), 0);
        chk("t6_async_done", int'(a_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_done", a_done_cnt - base, 0);
        chk("t6_idle", int'(a_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
